// File: rtl/pipe_ctrl.sv
// Pipeline control: stage write enables, bubble insertion and front-end stall counting.
// Define PIPE_MDU_EN to build in the multi-cycle MUL/DIV wait state (MDU_WAIT) and its down-counter.
module pipe_ctrl #(
    parameter int MDU_LAT = 32
) (
    input  logic        clk_cpu,
    input  logic        rst_cpu,
    input  logic        stop,
    input  logic        br_taken_ex,
    input  logic        mdu_req_ex,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        idex_we,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        mdu_start,
    output logic        mdu_busy,
    output logic [15:0] stall_cnt
);

    logic [15:0] stall_q, stall_d;

`ifdef PIPE_MDU_EN
    typedef enum logic {RUN, MDU_WAIT} state_t;

    localparam logic [7:0] CNT_LOAD = 8'(MDU_LAT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    always_ff @(posedge clk_cpu) begin
        if (rst_cpu) begin
            state_q <= RUN;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    logic unused_mdu;
    assign unused_mdu = mdu_req_ex ^ (MDU_LAT == 0);
`endif

    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        mdu_start   = 1'b0;
        mdu_busy    = 1'b0;
`ifdef PIPE_MDU_EN
        state_d     = state_q;
        cnt_d       = cnt_q;
        mdu_busy    = (state_q == MDU_WAIT);
`endif
        if (rst_cpu) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            idex_we = 1'b0;
        end
`ifdef PIPE_MDU_EN
        // Counting down: front end frozen and EX/MEM held empty; branch/stop are don't-care.
        else if (state_q == MDU_WAIT && cnt_q != 8'd0) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_flush = 1'b1;
            cnt_d       = cnt_q - 8'd1;
        end
        else if (state_q == RUN && !br_taken_ex && mdu_req_ex) begin
            mdu_start   = 1'b1;
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_flush = 1'b1;
            cnt_d       = CNT_LOAD;
            state_d     = MDU_WAIT;
        end
`endif
        else if (br_taken_ex) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end
        else if (stop) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
        end
`ifdef PIPE_MDU_EN
        // Release cycle takes normal RUN rules above and never retriggers the MDU.
        if (!rst_cpu && state_q == MDU_WAIT && cnt_q == 8'd0) begin
            state_d = RUN;
        end
`endif
        stall_d = stall_q;
        if (!pc_we && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk_cpu) begin
        if (rst_cpu) begin
            stall_q <= 16'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;

endmodule
